// File: rtl/parallel_window_buf.sv
`default_nettype none
// =============================================================================
// parallel_window_buf : beat-in / sliding-window / slice-out buffer for the PE array.
// Optional feature macro: PARALLEL_RANGE_CHECK_EN (out-of-range read detection).
// Revision: 1.0
// =============================================================================
module parallel_window_buf #(
  parameter int WORD_WIDTH  = 24,
  parameter int IN_WORDS    = 3,
  parameter int WIN_WORDS   = 18,
  parameter int OUT_WORDS   = 3,
  parameter int INDEX_WIDTH = 5
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            mode,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [IN_WORDS*WORD_WIDTH-1:0]  in_data,
  input  logic                            rd_req,
  output logic                            rd_ready,
  input  logic [INDEX_WIDTH-1:0]          wei_index,
  input  logic                            reused,
  input  logic                            row_done,
  input  logic                            frame_done,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [OUT_WORDS*WORD_WIDTH-1:0] out_data,
  output logic [INDEX_WIDTH-1:0]          base_index,
  output logic [INDEX_WIDTH-1:0]          fill_count,
  output logic                            range_err
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_FULL  = 2'd2,
    ST_SLIDE = 2'd3
  } state_t;

  localparam int OFF_W = INDEX_WIDTH + 1;
  localparam int AW    = (WIN_WORDS > 1) ? $clog2(WIN_WORDS) : 1;

  state_t                          state_q, state_d;
  logic [WORD_WIDTH-1:0]           win_q [WIN_WORDS];
  logic [WORD_WIDTH-1:0]           win_d [WIN_WORDS];
  logic [INDEX_WIDTH-1:0]          base_q, base_d;
  logic [INDEX_WIDTH-1:0]          fill_q, fill_d;
  logic                            out_valid_q, out_valid_d;
  logic [OUT_WORDS*WORD_WIDTH-1:0] out_data_q, out_data_d;
  logic                            range_err_q, range_err_d;

  logic                            out_free;
  logic                            pass_mode;
  logic                            beat_acc;
  logic                            rd_acc;
  logic [INDEX_WIDTH-1:0]          base_sel;
  logic [INDEX_WIDTH-1:0]          rd_off;
  logic                            slice_oob;
  logic [OUT_WORDS*WORD_WIDTH-1:0] slice;
  logic [OUT_WORDS*WORD_WIDTH-1:0] pass_data;
  logic [OFF_W-1:0]                fill_sum;
  logic [OFF_W-1:0]                base_sum;

  assign out_free  = !out_valid_q || out_ready;
  assign pass_mode = (state_q == ST_EMPTY) && !mode;
  assign base_sel  = reused ? base_q : '0;
  assign fill_sum  = {1'b0, fill_q} + OFF_W'(IN_WORDS);
  assign base_sum  = {1'b0, base_q} + OFF_W'(IN_WORDS);

`ifdef PARALLEL_RANGE_CHECK_EN
  logic [OFF_W-1:0] offset_full;
  assign offset_full = {1'b0, wei_index} + {1'b0, base_sel};
  assign rd_off      = offset_full[INDEX_WIDTH-1:0];
  assign slice_oob   = ({1'b0, offset_full} + (OFF_W+1)'(OUT_WORDS)) > (OFF_W+1)'(WIN_WORDS);
`else
  assign rd_off      = wei_index + base_sel;
  assign slice_oob   = 1'b0;
`endif

  // Words past the top of the window read as zero.
  for (genvar k = 0; k < OUT_WORDS; k++) begin : g_slice
    logic [OFF_W-1:0] idx;
    assign idx = {1'b0, rd_off} + OFF_W'(k);
    assign slice[k*WORD_WIDTH +: WORD_WIDTH] =
      (idx < OFF_W'(WIN_WORDS)) ? win_q[idx[AW-1:0]] : '0;
  end

  if (IN_WORDS >= OUT_WORDS) begin : g_pass_trunc
    assign pass_data = in_data[OUT_WORDS*WORD_WIDTH-1:0];
  end else begin : g_pass_zext
    assign pass_data = {{((OUT_WORDS-IN_WORDS)*WORD_WIDTH){1'b0}}, in_data};
  end

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      ST_EMPTY:          in_ready = mode ? 1'b1 : out_free;
      ST_FILL, ST_SLIDE: in_ready = 1'b1;
      default:           in_ready = 1'b0;
    endcase
    // A flush wins over a beat arriving in the same cycle.
    if (frame_done || !reset) begin
      in_ready = 1'b0;
    end
  end

  assign rd_ready = (state_q == ST_FULL) && out_free;
  assign beat_acc = in_valid && in_ready;
  assign rd_acc   = rd_req && rd_ready;

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    base_d      = base_q;
    win_d       = win_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    range_err_d = range_err_q;

    if (rd_acc) begin
      out_valid_d = 1'b1;
      out_data_d  = slice_oob ? '0 : slice;
      range_err_d = range_err_q || slice_oob;
    end else if (beat_acc && pass_mode) begin
      out_valid_d = 1'b1;
      out_data_d  = pass_data;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (beat_acc && !pass_mode) begin
      for (int i = 0; i < WIN_WORDS - IN_WORDS; i++) begin
        win_d[i] = win_q[i + IN_WORDS];
      end
      for (int k = 0; k < IN_WORDS; k++) begin
        win_d[WIN_WORDS - IN_WORDS + k] = in_data[k*WORD_WIDTH +: WORD_WIDTH];
      end
      fill_d = (fill_sum >= OFF_W'(WIN_WORDS)) ? INDEX_WIDTH'(WIN_WORDS)
                                               : fill_sum[INDEX_WIDTH-1:0];
    end

    case (state_q)
      ST_EMPTY: begin
        if (beat_acc && mode) begin
          state_d = (fill_sum >= OFF_W'(WIN_WORDS)) ? ST_FULL : ST_FILL;
        end
      end
      ST_FILL: begin
        if (beat_acc && (fill_sum >= OFF_W'(WIN_WORDS))) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (row_done) begin
          if (!reused) begin
            state_d = ST_SLIDE;
          end else begin
            base_d = (base_sum >= OFF_W'(WIN_WORDS)) ? '0 : base_sum[INDEX_WIDTH-1:0];
          end
        end
      end
      ST_SLIDE: begin
        if (beat_acc) begin
          state_d = ST_FULL;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    if (frame_done) begin
      state_d     = ST_EMPTY;
      fill_d      = '0;
      base_d      = '0;
      range_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_EMPTY;
      fill_q      <= '0;
      base_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      range_err_q <= 1'b0;
      for (int i = 0; i < WIN_WORDS; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      base_q      <= base_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      range_err_q <= range_err_d;
      for (int i = 0; i < WIN_WORDS; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign base_index = base_q;
  assign fill_count = fill_q;
  assign range_err  = range_err_q;

endmodule
`default_nettype wire

// File: tb/tb_parallel_window_buf.sv
`default_nettype none
// =============================================================================
// tb_parallel_window_buf : scoreboard bench with a queue-based window model.
// Revision: 1.0
// =============================================================================
module tb_parallel_window_buf;

  localparam int WW  = 24;
  localparam int IW  = 3;
  localparam int WIN = 18;
  localparam int OW  = 3;
  localparam int XW  = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             mode = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IW*WW-1:0] in_data = '0;
  logic             rd_req = 1'b0;
  logic             rd_ready;
  logic [XW-1:0]    wei_index = '0;
  logic             reused = 1'b0;
  logic             row_done = 1'b0;
  logic             frame_done = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [OW*WW-1:0] out_data;
  logic [XW-1:0]    base_index;
  logic [XW-1:0]    fill_count;
  logic             range_err;

  always #5 clk = ~clk;

  parallel_window_buf #(
    .WORD_WIDTH(WW), .IN_WORDS(IW), .WIN_WORDS(WIN), .OUT_WORDS(OW), .INDEX_WIDTH(XW)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .rd_req(rd_req), .rd_ready(rd_ready), .wei_index(wei_index),
    .reused(reused), .row_done(row_done), .frame_done(frame_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .base_index(base_index), .fill_count(fill_count), .range_err(range_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  logic [OW*WW-1:0] sb [$];

  // Reference model: 0 EMPTY, 1 FILL, 2 FULL, 3 SLIDE; window as a queue, oldest first.
  int            m_state = 0;
  logic [WW-1:0] m_win [$];
  int            m_base = 0;
  bit            m_valid = 1'b0;
  bit            m_rerr = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [IW*WW-1:0] beat(input int b);
    logic [IW*WW-1:0] r;
    for (int k = 0; k < IW; k++) r[k*WW +: WW] = WW'(IW*b + k);
    return r;
  endfunction

  function automatic bit m_oob(input int wei, input bit re);
`ifdef PARALLEL_RANGE_CHECK_EN
    return (wei + (re ? m_base : 0) + OW) > WIN;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [OW*WW-1:0] m_slice(input int wei, input bit re);
    logic [OW*WW-1:0] r;
    int off;
    r   = '0;
    off = (wei + (re ? m_base : 0)) % (1 << XW);
    if (m_oob(wei, re)) return r;
    for (int k = 0; k < OW; k++)
      if (off + k < m_win.size()) r[k*WW +: WW] = m_win[off + k];
    return r;
  endfunction

  // One clock of stimulus: check the model's view at the falling edge, advance the model.
  task automatic tick(output bit acc_in);
    bit free, e_in, e_rd, acc_rd, pt;
    @(negedge clk);
    free = !m_valid || out_ready;
    if (frame_done)                    e_in = 1'b0;
    else if (m_state == 0)             e_in = mode ? 1'b1 : free;
    else                               e_in = (m_state == 1) || (m_state == 3);
    e_rd = (m_state == 2) && free;
    chk("in_ready",   in_ready,   e_in);
    chk("rd_ready",   rd_ready,   e_rd);
    chk("out_valid",  out_valid,  m_valid);
    chk("fill_count", fill_count, m_win.size());
    chk("base_index", base_index, m_base);
    chk("range_err",  range_err,  m_rerr);
    if (m_valid && !out_ready && sb.size() > 0) chk("held_data", out_data, sb[0]);
    acc_in = in_valid && e_in;
    acc_rd = rd_req && e_rd;
    pt     = (m_state == 0) && !mode;
    #1;
    if (acc_rd) begin
      sb.push_back(m_slice(int'(wei_index), reused));
      if (m_oob(int'(wei_index), reused)) m_rerr = 1'b1;
      m_valid = 1'b1;
    end else if (acc_in && pt) begin
      sb.push_back(in_data[OW*WW-1:0]);
      m_valid = 1'b1;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    if (acc_in && !pt) begin
      for (int k = 0; k < IW; k++) m_win.push_back(in_data[k*WW +: WW]);
      while (m_win.size() > WIN) void'(m_win.pop_front());
    end
    case (m_state)
      0: if (acc_in && mode) m_state = (m_win.size() == WIN) ? 2 : 1;
      1: if (acc_in && m_win.size() == WIN) m_state = 2;
      2: if (row_done) begin
           if (!reused) m_state = 3;
           else m_base = (m_base + IW >= WIN) ? 0 : m_base + IW;
         end
      3: if (acc_in) m_state = 2;
      default: m_state = 0;
    endcase
    if (frame_done) begin
      m_state = 0;
      m_win.delete();
      m_base = 0;
      m_rerr = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (started && out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_output", 1, 0);
      else chk("out_data", out_data, sb.pop_front());
    end
  end

  initial begin
    bit a;
    int cnt;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",   in_ready,   0);
    chk("rst_rd_ready",   rd_ready,   0);
    chk("rst_out_valid",  out_valid,  0);
    chk("rst_out_data",   out_data,   0);
    chk("rst_base_index", base_index, 0);
    chk("rst_fill_count", fill_count, 0);
    chk("rst_range_err",  range_err,  0);
    reset = 1'b1;
    #1;
    chk("in_ready_after_release", in_ready, 1);
    started = 1'b1;

    // Fill: in_valid held, only six beats may be taken.
    mode = 1'b1; in_valid = 1'b1; cnt = 0;
    repeat (8) begin
      in_data = beat(cnt);
      tick(a);
      if (a) cnt++;
    end
    in_valid = 1'b0;
    chk("fill_beats_accepted", cnt, 6);

    // Plain reads, back to back.
    reused = 1'b0; rd_req = 1'b1;
    for (int w = 0; w <= 6; w += 3) begin
      wei_index = XW'(w);
      tick(a);
    end
    rd_req = 1'b0;
    tick(a);

    // Reuse: two base steps then a read, then wrap.
    reused = 1'b1; row_done = 1'b1;
    repeat (2) tick(a);
    row_done = 1'b0; rd_req = 1'b1; wei_index = 5'd1;
    tick(a);
    rd_req = 1'b0; row_done = 1'b1;
    repeat (4) tick(a);
    row_done = 1'b0;
    tick(a);
    chk("base_wrapped", base_index, 0);

    // Slide by exactly one beat.
    reused = 1'b0; row_done = 1'b1;
    tick(a);
    row_done = 1'b0; in_valid = 1'b1; in_data = beat(6); cnt = 0;
    repeat (2) begin
      tick(a);
      if (a) cnt++;
    end
    in_valid = 1'b0;
    chk("slide_beats_accepted", cnt, 1);
    rd_req = 1'b1; wei_index = 5'd0;
    tick(a);

    // Output back-pressure.
    wei_index = 5'd9;
    tick(a);
    out_ready = 1'b0;
    repeat (4) tick(a);
    out_ready = 1'b1; rd_req = 1'b0;
    tick(a);

    // Out-of-range offset, then flush.
    rd_req = 1'b1; wei_index = 5'd16;
    tick(a);
    rd_req = 1'b0;
    repeat (2) tick(a);
    frame_done = 1'b1;
    tick(a);
    frame_done = 1'b0;
    tick(a);

    // Passthrough, then a beat colliding with frame_done.
    mode = 1'b0; in_valid = 1'b1;
    in_data = {24'hAAAAA2, 24'hAAAAA1, 24'hAAAAA0};
    tick(a);
    in_data = {24'hBBBBB2, 24'hBBBBB1, 24'hBBBBB0};
    tick(a);
    frame_done = 1'b1;
    in_data = {24'hCCCCC2, 24'hCCCCC1, 24'hCCCCC0};
    tick(a);
    chk("frame_done_beat_blocked", a, 0);
    frame_done = 1'b0; in_valid = 1'b0;
    repeat (2) tick(a);

    // Randomized traffic.
    repeat (3000) begin
      mode       = ($urandom % 8) != 0;
      in_valid   = $urandom % 2;
      in_data    = {$urandom, $urandom, $urandom};
      rd_req     = $urandom % 2;
      wei_index  = XW'($urandom_range(0, 31));
      reused     = $urandom % 2;
      row_done   = ($urandom % 6) == 0;
      frame_done = ($urandom % 64) == 0;
      out_ready  = ($urandom % 4) != 0;
      if (frame_done) rd_req = 1'b0;
      tick(a);
    end

    mode = 1'b1; in_valid = 1'b0; rd_req = 1'b0; row_done = 1'b0;
    frame_done = 1'b0; out_ready = 1'b1;
    repeat (3) tick(a);
    chk("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
